// File: rtl/mem_bus_arbiter.sv
// Arbitrates the shared memory bus between fetch (IF) and data (MEM), data first; ready pulses 1 cycle after bus_ack.
// Requesters stall on stop_from_* while their access is outstanding. Optional ack watchdog: ARB_BUS_TIMEOUT_EN.
module mem_bus_arbiter #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        cpu_clk_75M,
  input  logic        cpu_rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  output logic        stop_from_if,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [3:0]  mem_be,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        stop_from_mem,
  input  logic        flush_i,
  output logic        bus_req,
  output logic        bus_we,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        bus_err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BUS_I = 2'd1;
  localparam logic [1:0] BUS_D = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0] state;
  logic       gnt_d;
  logic       drop;
  logic       wd_hit;

`ifdef ARB_BUS_TIMEOUT_EN
  logic [7:0] wd_cnt;
  logic       tmo;

  assign wd_hit = (wd_cnt == 8'(TIMEOUT_CYC - 1));

  always_ff @(posedge cpu_clk_75M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      wd_cnt <= 8'd0;
      tmo    <= 1'b0;
    end else begin
      case (state)
        BUS_I, BUS_D: begin
          if (!bus_ack) wd_cnt <= wd_cnt + 8'd1;
          tmo <= ~bus_ack & wd_hit;
        end
        RESP: ;
        default: begin
          wd_cnt <= 8'd0;
          tmo    <= 1'b0;
        end
      endcase
    end
  end

  assign bus_err = (state == RESP) & tmo;
`else
  logic [7:0] unused_timeout_cyc;

  assign unused_timeout_cyc = 8'(TIMEOUT_CYC);
  assign wd_hit  = 1'b0;
  assign bus_err = 1'b0;
`endif

  always_ff @(posedge cpu_clk_75M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state     <= IDLE;
      gnt_d     <= 1'b0;
      drop      <= 1'b0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_be    <= 4'h0;
      bus_addr  <= 32'h0;
      bus_wdata <= 32'h0;
      if_rdata  <= 32'h0;
      mem_rdata <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_req) begin
            state     <= BUS_D;
            gnt_d     <= 1'b1;
            bus_req   <= 1'b1;
            bus_we    <= mem_we;
            bus_be    <= mem_be;
            bus_addr  <= mem_addr;
            bus_wdata <= mem_wdata;
          end else if (if_req & ~flush_i) begin
            state    <= BUS_I;
            gnt_d    <= 1'b0;
            bus_req  <= 1'b1;
            bus_we   <= 1'b0;
            bus_be   <= 4'hF;
            bus_addr <= if_addr;
          end
        end
        BUS_I, BUS_D: begin
          // A flushed fetch still finishes on the bus; only its ready pulse is dropped.
          if (state == BUS_I && flush_i) drop <= 1'b1;
          if (bus_ack) begin
            bus_req <= 1'b0;
            state   <= RESP;
            if (gnt_d) mem_rdata <= bus_rdata;
            else       if_rdata  <= bus_rdata;
          end else if (wd_hit) begin
            bus_req <= 1'b0;
            state   <= RESP;
            if (gnt_d) mem_rdata <= 32'h0;
            else       if_rdata  <= 32'h0;
          end
        end
        default: begin
          drop  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign if_ready      = (state == RESP) & ~gnt_d & ~drop & ~flush_i;
  assign mem_ready     = (state == RESP) & gnt_d;
  assign stop_from_if  = if_req & ~if_ready;
  assign stop_from_mem = mem_req & ~mem_ready;

endmodule
